// File: rtl/mem_stage.sv
// RV32I memory-access stage: drives a variable-latency data port, stalls upstream
// while an access is outstanding, and registers the MEM/WB bundle.
module mem_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  input  logic [2:0]  i_func3,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic        i_RegWrite,
  input  logic [4:0]  i_rd_waddr,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_wen,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_mask,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ready,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_valid,
  output logic        o_wb_RegWrite,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_wb_misaligned,
  output logic        o_dbg_state
);

  // Handshake: o_dmem_req rises with a legal op and stays high, with stable
  // addr/mask/wdata/wen, until the cycle i_dmem_ready=1; that cycle completes the
  // access and carries valid read data. o_stall is high while req waits for ready.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state, state_n;

  logic        mem_op, f3_ok, mis, fault, legal;
  logic [1:0]  off;
  logic [3:0]  in_mask;
  logic [31:0] in_wdata;

  logic [31:0] addr_q, wdata_q;
  logic [3:0]  mask_q;
  logic        wen_q, regwrite_q;
  logic [2:0]  func3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;

  logic        latch;
  logic [2:0]  sel_f3;
  logic [1:0]  sel_off;
  logic [31:0] lane, load_data;

  assign o_dbg_state = state;

  always_comb begin
    mem_op = i_valid & (i_MemRead | i_MemWrite);
    off    = i_alu_result[1:0];
    if (i_MemRead)
      f3_ok = (i_func3 == 3'b000) | (i_func3 == 3'b001) | (i_func3 == 3'b010) |
              (i_func3 == 3'b100) | (i_func3 == 3'b101);
    else
      f3_ok = (i_func3 == 3'b000) | (i_func3 == 3'b001) | (i_func3 == 3'b010);
    mis   = ((i_func3[1:0] == 2'b01) & i_alu_result[0]) |
            ((i_func3[1:0] == 2'b10) & (|i_alu_result[1:0]));
    fault = mem_op & ((i_MemRead & i_MemWrite) | ~f3_ok | mis);
    legal = mem_op & ~fault;

    in_mask  = 4'b1111;
    in_wdata = i_store_data;
    if (i_MemWrite) begin
      case (i_func3[1:0])
        2'b00:   in_mask = 4'b0001 << off;
        2'b01:   in_mask = 4'b0011 << off;
        default: in_mask = 4'b1111;
      endcase
    end
    case (i_func3[1:0])
      2'b00:   in_wdata = {4{i_store_data[7:0]}};
      2'b01:   in_wdata = {2{i_store_data[15:0]}};
      default: in_wdata = i_store_data;
    endcase
  end

  always_comb begin
    state_n      = state;
    o_dmem_req   = 1'b0;
    o_dmem_wen   = 1'b0;
    o_dmem_addr  = 32'd0;
    o_dmem_mask  = 4'd0;
    o_dmem_wdata = 32'd0;
    o_stall      = 1'b0;
    latch        = 1'b0;
    sel_f3       = i_func3;
    sel_off      = off;
    case (state)
      IDLE: begin
        if (legal) begin
          o_dmem_req   = 1'b1;
          o_dmem_wen   = i_MemWrite;
          o_dmem_addr  = {i_alu_result[31:2], 2'b00};
          o_dmem_mask  = in_mask;
          o_dmem_wdata = in_wdata;
          if (!i_dmem_ready) begin
            o_stall = 1'b1;
            latch   = 1'b1;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        // Upstream is frozen, but only the latched copy is trusted here.
        o_dmem_req   = 1'b1;
        o_dmem_wen   = wen_q;
        o_dmem_addr  = addr_q;
        o_dmem_mask  = mask_q;
        o_dmem_wdata = wdata_q;
        sel_f3       = func3_q;
        sel_off      = off_q;
        if (i_dmem_ready) state_n = IDLE;
        else              o_stall = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    lane = i_dmem_rdata >> {sel_off, 3'b000};
    case (sel_f3)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'd0, lane[7:0]};
      3'b101:  load_data = {16'd0, lane[15:0]};
      default: load_data = i_dmem_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= IDLE;
      addr_q          <= 32'd0;
      wdata_q         <= 32'd0;
      mask_q          <= 4'd0;
      wen_q           <= 1'b0;
      regwrite_q      <= 1'b0;
      func3_q         <= 3'd0;
      off_q           <= 2'd0;
      rd_q            <= 5'd0;
      o_wb_valid      <= 1'b0;
      o_wb_RegWrite   <= 1'b0;
      o_wb_rd         <= 5'd0;
      o_wb_data       <= 32'd0;
      o_wb_misaligned <= 1'b0;
    end else begin
      state <= state_n;
      if (latch) begin
        addr_q     <= {i_alu_result[31:2], 2'b00};
        wdata_q    <= in_wdata;
        mask_q     <= in_mask;
        wen_q      <= i_MemWrite;
        regwrite_q <= i_RegWrite & ~i_MemWrite;
        func3_q    <= i_func3;
        off_q      <= off;
        rd_q       <= i_rd_waddr;
      end
      o_wb_valid      <= 1'b0;
      o_wb_RegWrite   <= 1'b0;
      o_wb_rd         <= 5'd0;
      o_wb_data       <= 32'd0;
      o_wb_misaligned <= 1'b0;
      if (!o_stall) begin
        if (state == BUSY) begin
          o_wb_valid    <= 1'b1;
          o_wb_RegWrite <= regwrite_q;
          o_wb_rd       <= rd_q;
          o_wb_data     <= wen_q ? 32'd0 : load_data;
        end else if (i_valid) begin
          o_wb_valid <= 1'b1;
          o_wb_rd    <= i_rd_waddr;
          if (fault) begin
            o_wb_misaligned <= 1'b1;
          end else if (legal && i_MemWrite) begin
            o_wb_RegWrite <= 1'b0;
          end else if (legal) begin
            o_wb_RegWrite <= i_RegWrite;
            o_wb_data     <= load_data;
          end else begin
            o_wb_RegWrite <= i_RegWrite;
            o_wb_data     <= i_alu_result;
          end
        end
      end
    end
  end

endmodule
